// File: rtl/imuldiv_int_div_arbiter_pkg.sv
// rtl/imuldiv_int_div_arbiter_pkg.sv - shared constants and FSM encoding for the divider arbiter
//
// Purpose : operand/result widths and the 2-bit arbiter state encoding
//           shared by the interface, the picker and the top.
// Ports   : none (package)
package imuldiv_int_div_arbiter_pkg;

  localparam int IMULDIV_DIV_ARB_OPND_W   = 32;
  localparam int IMULDIV_DIV_ARB_RESULT_W = 64;

  typedef enum logic [1:0] {
    IMULDIV_DIV_ARB_IDLE  = 2'd0,
    IMULDIV_DIV_ARB_ISSUE = 2'd1,
    IMULDIV_DIV_ARB_WAIT  = 2'd2,
    IMULDIV_DIV_ARB_RESP  = 2'd3
  } div_arb_state_e;

endpackage

// File: rtl/imuldiv_int_div_arbiter_if.sv
// rtl/imuldiv_int_div_arbiter_if.sv - requester and divider handshake bundle for the divider arbiter
//
// Purpose : groups the per-requester val/rdy ports and the single divider
//           request/response port pair.
// Modports: master - the arbiter view (drives reqs_rdy, resps_*, divreq_*, divresp_rdy)
//           slave  - the surrounding requesters and divider
// Signals : reqs_msg_fn/a/b, reqs_val, reqs_rdy       requester -> arbiter
//           resps_msg_result, resps_val, resps_rdy    arbiter -> requester
//           divreq_msg_fn/a/b, divreq_val, divreq_rdy arbiter -> divider
//           divresp_msg_result, divresp_val, divresp_rdy divider -> arbiter
interface imuldiv_int_div_arbiter_if
  import imuldiv_int_div_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]                          reqs_msg_fn;
  logic [IMULDIV_DIV_ARB_OPND_W*NUM_REQ-1:0]   reqs_msg_a;
  logic [IMULDIV_DIV_ARB_OPND_W*NUM_REQ-1:0]   reqs_msg_b;
  logic [NUM_REQ-1:0]                          reqs_val;
  logic [NUM_REQ-1:0]                          reqs_rdy;

  logic [IMULDIV_DIV_ARB_RESULT_W-1:0]         resps_msg_result;
  logic [NUM_REQ-1:0]                          resps_val;
  logic [NUM_REQ-1:0]                          resps_rdy;

  logic                                        divreq_msg_fn;
  logic [IMULDIV_DIV_ARB_OPND_W-1:0]           divreq_msg_a;
  logic [IMULDIV_DIV_ARB_OPND_W-1:0]           divreq_msg_b;
  logic                                        divreq_val;
  logic                                        divreq_rdy;

  logic [IMULDIV_DIV_ARB_RESULT_W-1:0]         divresp_msg_result;
  logic                                        divresp_val;
  logic                                        divresp_rdy;

  modport master (
    input  reqs_msg_fn, reqs_msg_a, reqs_msg_b, reqs_val,
    output reqs_rdy,
    output resps_msg_result, resps_val,
    input  resps_rdy,
    output divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
    input  divreq_rdy,
    input  divresp_msg_result, divresp_val,
    output divresp_rdy
  );

  modport slave (
    output reqs_msg_fn, reqs_msg_a, reqs_msg_b, reqs_val,
    input  reqs_rdy,
    input  resps_msg_result, resps_val,
    output resps_rdy,
    input  divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
    output divreq_rdy,
    output divresp_msg_result, divresp_val,
    input  divresp_rdy
  );

endinterface

// File: rtl/imuldiv_rr_priority_picker.sv
// rtl/imuldiv_rr_priority_picker.sv - combinational round-robin winner selection
//
// Purpose : picks the first valid requester searching upward from
//           i_last_grant+1 (mod NUM_REQ), wrapping around.
// Ports   : i_reqs_val   [NUM_REQ]  request valids
//           i_last_grant [IDXW]     most recently granted index
//           o_grant      [NUM_REQ]  one-hot winner, zero if nobody is valid
//           o_grant_idx  [IDXW]     binary index of the winner
module imuldiv_rr_priority_picker
  import imuldiv_int_div_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_reqs_val,
  input  logic [IDXW-1:0]    i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDXW-1:0]    o_grant_idx
);

  logic            w_found;
  logic [IDXW-1:0] w_cand;

  // Offset 1 is searched first so the previous winner has lowest priority.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDXW'((int'(i_last_grant) + i) % NUM_REQ);
      if (!w_found && i_reqs_val[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_grant_idx     = w_cand;
      end
    end
  end

endmodule

// File: rtl/imuldiv_int_div_arbiter.sv
// rtl/imuldiv_int_div_arbiter.sv - round-robin sharing of one iterative divider between NUM_REQ requesters
//
// Purpose : grants one requester at a time, forwards its fn/a/b to the divider,
//           and routes the 64-bit {remainder, quotient} back to that requester.
//           Exactly one transaction is outstanding at any time.
// Ports   : clk, reset (asynchronous, active-high)
//           bus  imuldiv_int_div_arbiter_if.master - requester and divider handshakes
//           perf_busy_cycles, perf_xfer_count (32 each) - only when
//           IMULDIV_DIV_ARB_PERF_EN is defined
module imuldiv_int_div_arbiter
  import imuldiv_int_div_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  imuldiv_int_div_arbiter_if.master   bus
`ifdef IMULDIV_DIV_ARB_PERF_EN
  ,
  output logic [31:0]                 perf_busy_cycles,
  output logic [31:0]                 perf_xfer_count
`endif
);

  localparam int IDXW = $clog2(NUM_REQ);

  div_arb_state_e                      r_state, w_state_nxt;
  logic [IDXW-1:0]                     r_owner, r_last_grant, w_grant_idx;
  logic [NUM_REQ-1:0]                  w_grant;
  logic                                r_fn;
  logic [IMULDIV_DIV_ARB_OPND_W-1:0]   r_a, r_b;
  logic [IMULDIV_DIV_ARB_RESULT_W-1:0] r_result;
  logic                                w_accept, w_div_cap, w_resp_done;

  imuldiv_rr_priority_picker #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_picker (
    .i_reqs_val   (bus.reqs_val),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

  assign bus.divreq_msg_fn    = r_fn;
  assign bus.divreq_msg_a     = r_a;
  assign bus.divreq_msg_b     = r_b;
  assign bus.resps_msg_result = r_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IMULDIV_DIV_ARB_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = IMULDIV_DIV_ARB_IDLE;
    bus.reqs_rdy    = '0;
    bus.resps_val   = '0;
    bus.divreq_val  = 1'b0;
    bus.divresp_rdy = 1'b0;
    w_accept        = 1'b0;
    w_div_cap       = 1'b0;
    w_resp_done     = 1'b0;
    case (r_state)
      IMULDIV_DIV_ARB_IDLE: begin
        // reqs_rdy is the only combinational output; reset masks it so no
        // requester sees a grant while the block is held in reset.
        bus.reqs_rdy = reset ? '0 : w_grant;
        w_accept     = |w_grant;
        w_state_nxt  = w_accept ? IMULDIV_DIV_ARB_ISSUE : IMULDIV_DIV_ARB_IDLE;
      end
      IMULDIV_DIV_ARB_ISSUE: begin
        bus.divreq_val = 1'b1;
        w_state_nxt    = bus.divreq_rdy ? IMULDIV_DIV_ARB_WAIT : IMULDIV_DIV_ARB_ISSUE;
      end
      IMULDIV_DIV_ARB_WAIT: begin
        bus.divresp_rdy = 1'b1;
        w_div_cap       = bus.divresp_val;
        w_state_nxt     = w_div_cap ? IMULDIV_DIV_ARB_RESP : IMULDIV_DIV_ARB_WAIT;
      end
      IMULDIV_DIV_ARB_RESP: begin
        bus.resps_val[r_owner] = 1'b1;
        w_resp_done            = bus.resps_rdy[r_owner];
        w_state_nxt            = w_resp_done ? IMULDIV_DIV_ARB_IDLE : IMULDIV_DIV_ARB_RESP;
      end
      default: begin
        w_state_nxt = IMULDIV_DIV_ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner      <= '0;
      r_last_grant <= IDXW'(NUM_REQ - 1);
      r_fn         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_result     <= '0;
    end else begin
      if (w_accept) begin
        r_owner      <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_fn         <= bus.reqs_msg_fn[w_grant_idx];
        r_a          <= bus.reqs_msg_a[int'(w_grant_idx)*IMULDIV_DIV_ARB_OPND_W +: IMULDIV_DIV_ARB_OPND_W];
        r_b          <= bus.reqs_msg_b[int'(w_grant_idx)*IMULDIV_DIV_ARB_OPND_W +: IMULDIV_DIV_ARB_OPND_W];
      end
      if (w_div_cap) begin
        r_result <= bus.divresp_msg_result;
      end
    end
  end

`ifdef IMULDIV_DIV_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy_cycles <= '0;
      perf_xfer_count  <= '0;
    end else begin
      if (r_state != IMULDIV_DIV_ARB_IDLE) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (w_resp_done)                     perf_xfer_count  <= perf_xfer_count + 32'd1;
    end
  end
`endif

endmodule
